div_issue: RTL and testbench
============================

Name: div_issue

Overview:
- EX-side initiator for the multi-cycle divider handshake. It accepts a DIV/DIVU operation from EX and latches the operands.
- It drives start, annul, signed and the operands to the divider, holds the pipeline via a stall request, and captures the 64-bit result.
- It presents the result as a one-shot HI/LO write toward EX/MEM.
- It handles divide-by-zero locally, plus flush and a watchdog timeout.

Parameters:
- DATA_W, 32, operand width; the result is 2*DATA_W.
- TIMEOUT, 40, maximum BUSY cycles before forced annul.

Ports:
- clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous, active-high reset (1 = reset).
- op_valid_i  in  1  EX holds a DIV/DIVU this cycle.
- op_signed_i  in  1  1 = DIV, 0 = DIVU.
- opdata1_i  in  DATA_W  dividend.
- opdata2_i  in  DATA_W  divisor.
- flush_i  in  1  cancel the in-flight operation.
- hold_i  in  1  downstream stall; EX/MEM not advancing.
- div_result_i  in  2*DATA_W  {remainder, quotient} from the divider.
- div_ready_i  in  1  divider result valid.
- div_start_o  out  1  request to divider; held high while busy.
- div_annul_o  out  1  one-cycle abort pulse to divider.
- div_signed_o  out  1  latched signed flag.
- div_opdata1_o  out  DATA_W  latched dividend.
- div_opdata2_o  out  DATA_W  latched divisor.
- stall_req_o  out  1  stall request to ctrl.
- whilo_o  out  1  HI/LO write enable toward EX/MEM.
- hi_o  out  DATA_W  remainder.
- lo_o  out  DATA_W  quotient.
- dbz_o  out  1  result came from divide-by-zero.
- timeout_o  out  1  sticky: a watchdog abort occurred.

Behaviour:
- Reset (async, Rst_n=1):
  - State goes to IDLE.
  - All registered outputs and operand/result registers clear to 0, including timeout_o and the cycle counter.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept condition: op_valid_i & !flush_i. On accept, latch opdata1/opdata2/signed.
  - If opdata2_i==0: go to DONE with hi=lo=0 and dbz=1. The divider is never started.
  - Otherwise: go to BUSY, clear the counter, dbz=0.
  - stall_req_o is combinationally 1 in the accept cycle.
- BUSY:
  - div_start_o=1 and stall_req_o=1. The counter increments each cycle.
  - On div_ready_i & !flush_i: capture hi=div_result_i[2*DATA_W-1:DATA_W] and lo=div_result_i[DATA_W-1:0], then go to DONE. div_start_o drops the following cycle.
  - On flush_i: div_annul_o=1 for exactly the next cycle, start drops, go to IDLE, stall_req_o=0 combinationally that cycle. Flush wins over a simultaneous ready; that result is discarded.
  - When the counter reaches TIMEOUT-1 without ready: annul pulse, set timeout_o, go to DONE with hi=lo=0, dbz=0.
- DONE:
  - stall_req_o=0.
  - whilo_o = !flush_i (combinational gate); hi_o/lo_o stable.
  - hold_i=1: remain in DONE with outputs held.
  - hold_i=0: return to IDLE at the next edge; the next instruction enters EX on that same edge.
  - flush_i: go to IDLE; whilo_o is 0 in that cycle.
- div_opdata*/div_signed_o hold the latched values from accept until the next accept; they are not cleared on completion.
- Operands must stay stable at the divider for the whole BUSY period; the latches guarantee this regardless of EX inputs.
- op_valid_i during BUSY/DONE is ignored; it is the same stalled instruction.
- Latency:
  - Accept at edge N; div_start_o high from cycle N+1.
  - Ready seen at cycle M gives whilo_o=1 at cycle M+1.
  - Divide-by-zero gives whilo_o=1 at cycle N+1.
- Reset mid-BUSY: divider start drops immediately, no annul pulse, all state cleared.
- timeout_o clears only on reset.

Test Plan:
- DIV -7 / 2, divider model ready after 33 cycles with {0xFFFFFFFF, 0xFFFFFFFD}:
  - div_start_o high 33 cycles, stall_req_o high throughout.
  - Next cycle whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD, div_signed_o=1.
- DIVU 100 / 0: the cycle after accept, whilo_o=1, hi_o=lo_o=0, dbz_o=1, div_start_o never asserted, stall only in the accept cycle.
- Flush at BUSY cycle 10:
  - div_annul_o single-cycle pulse, start low, state IDLE, whilo_o never asserted.
  - A ready asserted in the same cycle as flush is ignored.
- Done with hold_i=1 for 3 cycles: whilo_o/hi_o/lo_o held 3 cycles, then IDLE; a back-to-back DIVU 9/4 then yields lo=2, hi=1.
- Divider never ready, TIMEOUT=40: after 40 BUSY cycles annul pulse, timeout_o=1 and sticky, whilo_o=1 with hi=lo=0.
- Assert Rst_n mid-BUSY (async, between edges): all outputs 0 immediately, including stall_req_o and div_start_o; a subsequent op is accepted normally.

Source files
------------

// File: rtl/div_issue.sv
// div_issue: EX-side initiator for the multi-cycle divider handshake.
// Latches a DIV/DIVU, stalls EX while the divider runs, then returns a one-shot HI/LO write.
module div_issue #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                  clk,
  input  logic                  Rst_n,
  input  logic                  op_valid_i,
  input  logic                  op_signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  flush_i,
  input  logic                  hold_i,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i,
  output logic                  div_start_o,
  output logic                  div_annul_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opdata1_o,
  output logic [DATA_W-1:0]     div_opdata2_o,
  output logic                  stall_req_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  dbz_o,
  output logic                  timeout_o
);

  localparam int unsigned      RES_W    = 2 * DATA_W;
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                dbz_q, dbz_d;
  logic                timeout_q, timeout_d;
  logic                annul_q, annul_d;

  logic                accept;
  logic                div_by_zero;
  logic                expired;

  assign accept      = op_valid_i & ~flush_i;
  assign div_by_zero = (opdata2_i == '0);
  assign expired     = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge Rst_n) begin
    if (Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush beats a simultaneous ready, ready beats the watchdog
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = div_by_zero ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div_ready_i || expired) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || !hold_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: stall and the HI/LO write are gated live by flush
  always_comb begin
    stall_req_o = 1'b0;
    whilo_o     = 1'b0;
    unique case (state_q)
      S_IDLE:  stall_req_o = accept;
      S_BUSY:  stall_req_o = ~flush_i;
      S_DONE:  whilo_o     = ~flush_i;
      default: ;
    endcase
  end

  // Operand latch, result capture, watchdog counter and annul pulse
  always_comb begin
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    timeout_d = timeout_q;
    annul_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          signed_d = op_signed_i;
          op1_d    = opdata1_i;
          op2_d    = opdata2_i;
          cnt_d    = '0;
          dbz_d    = div_by_zero;
          if (div_by_zero) begin
            hi_d = '0;
            lo_d = '0;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) begin
          annul_d = 1'b1;
        end else if (div_ready_i) begin
          hi_d = div_result_i[RES_W-1:DATA_W];
          lo_d = div_result_i[DATA_W-1:0];
        end else if (expired) begin
          annul_d   = 1'b1;
          timeout_d = 1'b1;
          hi_d      = '0;
          lo_d      = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Rst_n) begin
    if (Rst_n) begin
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
      timeout_q <= 1'b0;
      annul_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
      timeout_q <= timeout_d;
      annul_q   <= annul_d;
    end
  end

  // Start is decoded from the state register so reset drops it asynchronously
  assign div_start_o   = (state_q == S_BUSY);
  assign div_annul_o   = annul_q;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign hi_o          = hi_q;
  assign lo_o          = lo_q;
  assign dbz_o         = dbz_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: table-driven directed bench for div_issue plus hand-written flush/hold/reset sequences.
module tb_div_issue;

  logic        clk;
  logic        Rst_n;
  logic        op_valid_i;
  logic        op_signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        flush_i;
  logic        hold_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stall_req_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        dbz_o;
  logic        timeout_o;

  int checks;
  int errors;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    int          rdy;     // busy cycle in which the divider model raises ready (0 = never)
    logic [63:0] res;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          ebusy;
    logic        eannul;
    logic        eto;
  } vec_t;

  vec_t vecs [6];

  div_issue #(.DATA_W(32), .TIMEOUT(40)) dut (
    .clk          (clk),
    .Rst_n        (Rst_n),
    .op_valid_i   (op_valid_i),
    .op_signed_i  (op_signed_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .flush_i      (flush_i),
    .hold_i       (hold_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .stall_req_o  (stall_req_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .dbz_o        (dbz_o),
    .timeout_o    (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                              input int rdy, input logic [63:0] res, input logic [31:0] ehi,
                              input logic [31:0] elo, input logic edbz, input int ebusy,
                              input logic eannul, input logic eto);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.rdy = rdy; v.res = res;
    v.ehi = ehi; v.elo = elo; v.edbz = edbz; v.ebusy = ebusy;
    v.eannul = eannul; v.eto = eto;
    return v;
  endfunction

  // Issues one op and runs until the first whilo cycle; returns at the negedge of that cycle.
  task automatic run_op(input vec_t v, input string tag);
    int busy;
    bit got;
    bit busy_bad;
    @(posedge clk); #1;
    op_valid_i   = 1'b1;
    op_signed_i  = v.sgn;
    opdata1_i    = v.a;
    opdata2_i    = v.b;
    div_ready_i  = 1'b0;
    div_result_i = v.res;
    @(negedge clk);
    chk({tag, "_accept_stall"}, 64'(stall_req_o), 64'(1));
    chk({tag, "_accept_nostart"}, 64'(div_start_o), 64'(0));
    busy = 0; got = 1'b0; busy_bad = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(posedge clk); #1;
      op_valid_i  = 1'b0;
      opdata1_i   = $urandom;
      opdata2_i   = $urandom;
      div_ready_i = 1'b0;
      if (div_start_o) begin
        busy++;
        if (busy == v.rdy) div_ready_i = 1'b1;
      end
      @(negedge clk);
      if (whilo_o) got = 1'b1;
      else if (!div_start_o || !stall_req_o || div_opdata1_o !== v.a || div_opdata2_o !== v.b)
        busy_bad = 1'b1;
    end
    div_ready_i = 1'b0;
    chk({tag, "_whilo_seen"}, 64'(got), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(busy), 64'(v.ebusy));
    chk({tag, "_busy_stall_operands"}, 64'(busy_bad), 64'(0));
    chk({tag, "_hi"}, 64'(hi_o), 64'(v.ehi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(v.elo));
    chk({tag, "_dbz"}, 64'(dbz_o), 64'(v.edbz));
    chk({tag, "_signed"}, 64'(div_signed_o), 64'(v.sgn));
    chk({tag, "_annul"}, 64'(div_annul_o), 64'(v.eannul));
    chk({tag, "_timeout"}, 64'(timeout_o), 64'(v.eto));
    chk({tag, "_done_nostart"}, 64'(div_start_o), 64'(0));
    chk({tag, "_done_nostall"}, 64'(stall_req_o), 64'(0));
    chk({tag, "_opdata1_kept"}, 64'(div_opdata1_o), 64'(v.a));
    chk({tag, "_opdata2_kept"}, 64'(div_opdata2_o), 64'(v.b));
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_whilo"}, 64'(whilo_o), 64'(0));
    chk({tag, "_idle_stall"}, 64'(stall_req_o), 64'(0));
    chk({tag, "_idle_annul"}, 64'(div_annul_o), 64'(0));
    chk({tag, "_idle_start"}, 64'(div_start_o), 64'(0));
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    Rst_n = 1'b1;
    op_valid_i = 1'b0; op_signed_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
    flush_i = 1'b0; hold_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;

    vecs[0] = mk(1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 32'd100, 32'd0, 0, 64'h1234_5678_9ABC_DEF0,
                 32'd0, 32'd0, 1'b1, 0, 1'b0, 1'b0);
    vecs[2] = mk(1'b0, 32'd9, 32'd4, 5, {32'd1, 32'd2},
                 32'd1, 32'd2, 1'b0, 5, 1'b0, 1'b0);
    vecs[3] = mk(1'b0, 32'h8000_0000, 32'd3, 1, {32'd2, 32'h2AAA_AAAA},
                 32'd2, 32'h2AAA_AAAA, 1'b0, 1, 1'b0, 1'b0);
    vecs[4] = mk(1'b1, 32'hFFFF_FFFB, 32'd0, 0, 64'hFFFF_0000_FFFF_0000,
                 32'd0, 32'd0, 1'b1, 0, 1'b0, 1'b0);
    vecs[5] = mk(1'b0, 32'd50, 32'd7, 0, 64'hDEAD_BEEF_CAFE_F00D,
                 32'd0, 32'd0, 1'b0, 40, 1'b1, 1'b1);

    // Reset state
    @(posedge clk); #1;
    chk("rst_state_start", 64'(div_start_o), 64'(0));
    chk("rst_state_whilo", 64'(whilo_o), 64'(0));
    chk("rst_state_timeout", 64'(timeout_o), 64'(0));
    chk("rst_state_hi_lo", {hi_o, lo_o}, 64'(0));
    chk("rst_state_opdata", {div_opdata1_o, div_opdata2_o}, 64'(0));
    @(negedge clk);
    Rst_n = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end

    // Flush at busy cycle 10 with a coincident ready that must be dropped
    @(posedge clk); #1;
    op_valid_i = 1'b1; op_signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    @(negedge clk);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = {32'd6, 32'd142};
    @(negedge clk);
    chk("flush_stall_drop", 64'(stall_req_o), 64'(0));
    chk("flush_start_still_busy", 64'(div_start_o), 64'(1));
    @(posedge clk); #1;
    flush_i = 1'b0; div_ready_i = 1'b0;
    @(negedge clk);
    chk("flush_annul_pulse", 64'(div_annul_o), 64'(1));
    chk("flush_start_low", 64'(div_start_o), 64'(0));
    chk("flush_no_whilo", 64'(whilo_o), 64'(0));
    chk("flush_timeout_sticky", 64'(timeout_o), 64'(1));
    idle_check("flush_after1");
    idle_check("flush_after2");

    // Hold in DONE for three cycles, then back-to-back DIVU 9/4
    hold_i = 1'b1;
    v = mk(1'b0, 32'd20, 32'd3, 4, {32'd2, 32'd6}, 32'd2, 32'd6, 1'b0, 4, 1'b0, 1'b1);
    run_op(v, "hold");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_whilo", 64'(whilo_o), 64'(1));
      chk("hold_hi_lo", {hi_o, lo_o}, {32'd2, 32'd6});
    end
    @(posedge clk); #1;
    hold_i = 1'b0;
    @(negedge clk);
    chk("hold_release_whilo", 64'(whilo_o), 64'(1));
    v = mk(1'b0, 32'd9, 32'd4, 3, {32'd1, 32'd2}, 32'd1, 32'd2, 1'b0, 3, 1'b0, 1'b1);
    run_op(v, "b2b");
    idle_check("b2b");

    // Flush while held in DONE suppresses the write
    hold_i = 1'b1;
    v = mk(1'b0, 32'd15, 32'd4, 2, {32'd3, 32'd3}, 32'd3, 32'd3, 1'b0, 2, 1'b0, 1'b1);
    run_op(v, "dflush");
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(negedge clk);
    chk("dflush_whilo_gated", 64'(whilo_o), 64'(0));
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("dflush_idle_whilo", 64'(whilo_o), 64'(0));
    chk("dflush_idle_stall", 64'(stall_req_o), 64'(0));
    hold_i = 1'b0;

    // Asynchronous reset mid-busy
    @(posedge clk); #1;
    op_valid_i = 1'b1; op_signed_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
    @(negedge clk);
    @(posedge clk); #1;
    op_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("mid_busy_start", 64'(div_start_o), 64'(1));
    Rst_n = 1'b1;
    #1;
    chk("arst_start", 64'(div_start_o), 64'(0));
    chk("arst_stall", 64'(stall_req_o), 64'(0));
    chk("arst_annul", 64'(div_annul_o), 64'(0));
    chk("arst_whilo", 64'(whilo_o), 64'(0));
    chk("arst_timeout", 64'(timeout_o), 64'(0));
    chk("arst_signed", 64'(div_signed_o), 64'(0));
    chk("arst_opdata", {div_opdata1_o, div_opdata2_o}, 64'(0));
    @(negedge clk);
    Rst_n = 1'b0;
    v = mk(1'b0, 32'd9, 32'd4, 3, {32'd1, 32'd2}, 32'd1, 32'd2, 1'b0, 3, 1'b0, 1'b0);
    run_op(v, "post_rst");
    idle_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
